// File: rtl/uart_tx_bus_responder.sv
// Bus-mapped 8N1 UART transmitter: a 16-byte register window in front of a TX FIFO.
// Writes act on the request's rising edge, so a slow initiator holding a request pushes only once.
module uart_tx_bus_responder #(
    parameter logic [15:0] BASE_ADDR       = 16'h8000,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd1250
) (
    input  logic        raw_clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [31:0] data_in,
    input  logic [3:0]  write_mask,
    input  logic        bus_enable,
    input  logic        write_enable,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    tx_state_t state, state_nxt;

    logic                     sel, wr_req, wr_req_q, rd_req, wr_fire;
    logic [1:0]               off;
    logic                     push_req, push, pop, full, empty;
    logic                     ovf, ovf_clr, div_wr, busy;
    logic [FIFO_DEPTH-1:0][7:0] fifo_mem;
    logic [AW-1:0]            wptr, rptr;
    logic [CW-1:0]            count;
    logic [4:0]               cnt5;
    logic [3:0]               cnt4;
    logic [15:0]              divisor, bit_len, baud_cnt;
    logic                     bit_end;
    logic [7:0]               shreg;
    logic [2:0]               bit_idx;
    logic [31:0]              status, rd_mux;
    logic                     unused_bits;

    assign unused_bits = ^{address[1:0], data_in[31:16], write_mask[3:2]};

    // ---------------- bus decode ----------------
    assign sel     = (address[15:4] == BASE_ADDR[15:4]);
    assign off     = address[3:2];
    assign wr_req  = bus_enable & write_enable & sel;
    assign rd_req  = bus_enable & ~write_enable & sel;
    assign wr_fire = wr_req & ~wr_req_q;

    assign push_req = wr_fire & (off == 2'd0) & ~write_mask[0];
    assign ovf_clr  = wr_fire & (off == 2'd1) & ~write_mask[0] & data_in[3];
    assign div_wr   = wr_fire & (off == 2'd2);

    // Fullness uses the pre-cycle count: a pop in the same cycle does not make room.
    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = push_req & ~full;

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            wr_req_q   <= 1'b0;
            data_ready <= 1'b0;
            data_out   <= '0;
        end else begin
            wr_req_q   <= wr_req;
            data_ready <= bus_enable & sel;
            data_out   <= rd_req ? rd_mux : '0;
        end
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge raw_clk) begin
        if (push) fifo_mem[wptr] <= data_in[7:0];
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push_req & full) ovf <= 1'b1;
            else if (ovf_clr)    ovf <= 1'b0;
        end
    end

    // ---------------- divisor ----------------
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            divisor <= DEFAULT_DIVISOR;
        end else if (div_wr) begin
            if (!write_mask[0]) divisor[7:0]  <= data_in[7:0];
            if (!write_mask[1]) divisor[15:8] <= data_in[15:8];
        end
    end

    assign bit_len = (divisor == 16'd0) ? 16'd1 : divisor;
    assign bit_end = (baud_cnt == 16'd0);

    // ---------------- TX FSM ----------------
    always_ff @(posedge raw_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = START;
            START:   if (bit_end) state_nxt = DATA;
            DATA:    if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
            STOP:    if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop     = (state == IDLE) & ~empty;
        busy    = (state != IDLE);
        uart_tx = 1'b1;
        case (state)
            START:   uart_tx = 1'b0;
            DATA:    uart_tx = shreg[0];
            default: uart_tx = 1'b1;
        endcase
    end

    // Counter reloads from the live divisor at every bit boundary, so divisor
    // writes mid-frame apply from the next bit onward.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            baud_cnt <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
        end else if (pop) begin
            shreg    <= fifo_mem[rptr];
            baud_cnt <= bit_len - 16'd1;
            bit_idx  <= '0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                baud_cnt <= bit_len - 16'd1;
                if (state == DATA) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt - 16'd1;
            end
        end
    end

    // ---------------- read mux ----------------
    assign cnt5   = 5'(count);
    assign cnt4   = cnt5[4] ? 4'hF : cnt5[3:0];
    assign status = {20'h0, cnt4, 4'h0, ovf, busy, full, empty};

    always_comb begin
        rd_mux = '0;
        case (off)
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = {16'h0, divisor};
            default: rd_mux = '0;
        endcase
    end

endmodule
